adder_share_arbiter: RTL

- Shares one pipelined wide adder (fixed latency, no stall) among N requesters.
- Round-robin arbitration per cycle; registered issue into the adder.
- A tag pipeline tracks requester IDs through the adder and routes each sum back with its owner ID.
- Checks that the adder's out_valid lines up with the tracked tags.

---
 rtl/adder_share_arbiter_if.sv | 47 ++++
 rtl/adder_share_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter_if.sv
// Requester, adder and result signals of the shared-adder arbiter.
// Latency: none; this is a plain signal bundle.
// Backpressure: requesters see req_ready; adder and result sides never stall.
interface adder_share_arbiter_if #(
    parameter int N = 4,
    parameter int W = 128
);
    localparam int IDW = $clog2(N);

    logic           en;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;

    logic           add_in_valid;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic           add_out_valid;
    logic [W-1:0]   add_s;
    logic           add_cout;

    logic           res_valid;
    logic [IDW-1:0] res_id;
    logic [W-1:0]   res_s;
    logic           res_cout;
    logic           idle;
    logic           err;

    // Arbiter side
    modport slave (
        input  en, req_valid, req_a, req_b, req_cin,
        input  add_out_valid, add_s, add_cout,
        output req_ready, add_in_valid, add_a, add_b, add_cin,
        output res_valid, res_id, res_s, res_cout, idle, err
    );

    // Requester / adder / result consumer side
    modport master (
        output en, req_valid, req_a, req_b, req_cin,
        output add_out_valid, add_s, add_cout,
        input  req_ready, add_in_valid, add_a, add_b, add_cin,
        input  res_valid, res_id, res_s, res_cout, idle, err
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one fixed-latency pipelined adder among N requesters, with owner tag tracking.
// Latency: handshake to res_valid is LAT+2 cycles; one op per cycle sustained.
// Backpressure: only via req_ready (grant); adder and result path never stall.
module adder_share_arbiter #(
    parameter int N   = 4,
    parameter int W   = 128,
    parameter int LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    adder_share_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int BW  = $clog2(LAT + 1);

    logic [IDW-1:0] ptr;
    logic           grant_hit;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    logic [N-1:0]   ready_vec;

    logic           issue_vld;
    logic [IDW-1:0] issue_id;
    logic [W-1:0]   issue_a;
    logic [W-1:0]   issue_b;
    logic           issue_cin;

    logic [LAT-1:0] tag_vld;
    logic [IDW-1:0] tag_id [LAT];

    logic           res_vld;
    logic [IDW-1:0] res_id_q;
    logic [W-1:0]   res_s_q;
    logic           res_cout_q;
    logic           err_q;

    // The external adder has no reset, so ops issued before a reset can still
    // emerge for up to LAT cycles afterwards; those strobes are not errors.
    logic [BW-1:0]  blank_cnt;
    logic           mismatch;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = IDW'((int'(ptr) + k) % N);
            if (!grant_hit && bus.req_valid[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (reset || !bus.en) begin
            grant_hit = 1'b0;
        end
        ready_vec = grant_hit ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end

    // Pointer follows the most recent grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= IDW'(N - 1);
        end else if (grant_hit) begin
            ptr <= grant_idx;
        end
    end

    // Registered issue of the granted operands; operands hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_vld <= 1'b0;
            issue_id  <= '0;
            issue_a   <= '0;
            issue_b   <= '0;
            issue_cin <= 1'b0;
        end else begin
            issue_vld <= grant_hit;
            if (grant_hit) begin
                issue_id  <= grant_idx;
                issue_a   <= bus.req_a[int'(grant_idx)*W +: W];
                issue_b   <= bus.req_b[int'(grant_idx)*W +: W];
                issue_cin <= bus.req_cin[grant_idx];
            end
        end
    end

    // Tag pipe mirrors the adder; last stage aligns with add_out_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld[0] <= issue_vld;
            tag_id[0]  <= issue_id;
            for (int s = 1; s < LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Result register is driven by the tag, not by the adder's own strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_vld    <= 1'b0;
            res_id_q   <= '0;
            res_s_q    <= '0;
            res_cout_q <= 1'b0;
        end else begin
            res_vld <= tag_vld[LAT-1];
            if (tag_vld[LAT-1]) begin
                res_id_q   <= tag_id[LAT-1];
                res_s_q    <= bus.add_s;
                res_cout_q <= bus.add_cout;
            end
        end
    end

    // Post-reset window during which stale adder strobes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_cnt <= BW'(LAT);
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
        end
    end

    assign mismatch = (bus.add_out_valid != tag_vld[LAT-1])
                      && !((blank_cnt != '0) && !tag_vld[LAT-1]);

    // Sticky error on any tag/adder strobe disagreement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.add_in_valid = issue_vld;
    assign bus.add_a        = issue_a;
    assign bus.add_b        = issue_b;
    assign bus.add_cin      = issue_cin;
    assign bus.res_valid    = res_vld;
    assign bus.res_id       = res_id_q;
    assign bus.res_s        = res_s_q;
    assign bus.res_cout     = res_cout_q;
    assign bus.err          = err_q;
    assign bus.idle         = !issue_vld && (tag_vld == '0) && !res_vld;

endmodule
